// File: rtl/exunit_mul_pipe_pkg.sv
// rtl/exunit_mul_pipe_pkg.sv - payload type and product helpers for the multiply execution pipe
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef RRF_SEL
`define RRF_SEL 6
`endif
`ifndef SPECTAG_LEN
`define SPECTAG_LEN 5
`endif

package exunit_mul_pipe_pkg;

    // Everything an in-flight multiply carries between stages besides its valid bit.
    typedef struct packed {
        logic [`RRF_SEL-1:0]     rrftag;
        logic                    dstval;
        logic [`SPECTAG_LEN-1:0] spectag;
        logic                    specbit;
        logic                    sel_lohi;
        logic [2*`DATA_LEN-1:0]  prod;
    } mul_payload_t;

    // Low 2*DATA_LEN bits of the product of the two operands, each widened
    // by sign or zero extension. Widening to 2*DATA_LEN gives the same low
    // bits as the 33-bit by 33-bit form, so one unsigned multiply covers
    // all four signedness combinations.
    function automatic logic [2*`DATA_LEN-1:0] mul_prod(
        input logic [`DATA_LEN-1:0] a,
        input logic [`DATA_LEN-1:0] b,
        input logic                 a_signed,
        input logic                 b_signed
    );
        logic [2*`DATA_LEN-1:0] xa;
        logic [2*`DATA_LEN-1:0] xb;
        xa = {{`DATA_LEN{a_signed & a[`DATA_LEN-1]}}, a};
        xb = {{`DATA_LEN{b_signed & b[`DATA_LEN-1]}}, b};
        return xa * xb;
    endfunction

    // Pick the high or low word of a stored product.
    function automatic logic [`DATA_LEN-1:0] sel_word(input mul_payload_t p);
        return p.sel_lohi ? p.prod[2*`DATA_LEN-1:`DATA_LEN] : p.prod[`DATA_LEN-1:0];
    endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// rtl/mul_pipe_stage.sv - one multiply pipe register with mispredict squash and resolve clear
module mul_pipe_stage
    import exunit_mul_pipe_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  mul_payload_t            in_pl,
    input  logic                    prmiss,
    input  logic                    prsuccess,
    input  logic [`SPECTAG_LEN-1:0] prtag,
    input  logic [`SPECTAG_LEN-1:0] specfixtag,
    output logic                    valid,
    output mul_payload_t            pl
);

    logic squash;
    logic resolve;

    // A mispredict overrides a simultaneous resolve.
    assign squash  = prmiss & (|(in_pl.spectag & specfixtag));
    assign resolve = ~prmiss & prsuccess & (in_pl.spectag == prtag);

    // Capture the upstream op, dropping it on squash and clearing its speculative bit on resolve.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            pl    <= '0;
        end else begin
            valid <= in_valid & ~squash;
            pl    <= in_pl;
            if (resolve) begin
                pl.specbit <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exunit_mul_pipe.sv
// rtl/exunit_mul_pipe.sv - pipelined integer multiply unit; optional output register via MUL_OUT_REG_EN
module exunit_mul_pipe
    import exunit_mul_pipe_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue,
    input  logic [`DATA_LEN-1:0]    ex_src1,
    input  logic [`DATA_LEN-1:0]    ex_src2,
    input  logic                    src1_signed,
    input  logic                    src2_signed,
    input  logic                    sel_lohi,
    input  logic [`RRF_SEL-1:0]     rrftag,
    input  logic                    dstval,
    input  logic [`SPECTAG_LEN-1:0] spectag,
    input  logic                    specbit,
    input  logic                    prmiss,
    input  logic                    prsuccess,
    input  logic [`SPECTAG_LEN-1:0] prtag,
    input  logic [`SPECTAG_LEN-1:0] specfixtag,
    output logic [`DATA_LEN-1:0]    result,
    output logic                    rrf_we,
    output logic                    rob_we,
    output logic [`RRF_SEL-1:0]     wrrftag,
    output logic                    kill_spec,
    output logic [STAGES-1:0]       busy_stages
);

    mul_payload_t    issue_pl;
    mul_payload_t    stage_pl [STAGES+1];
    logic [STAGES:0] stage_valid;
    mul_payload_t    out_pl;
    logic            out_valid;

    // The full product is formed at issue and simply carried down the pipe.
    always_comb begin
        issue_pl          = '0;
        issue_pl.rrftag   = rrftag;
        issue_pl.dstval   = dstval;
        issue_pl.spectag  = spectag;
        issue_pl.specbit  = specbit;
        issue_pl.sel_lohi = sel_lohi;
        issue_pl.prod     = mul_prod(ex_src1, ex_src2, src1_signed, src2_signed);
    end

    assign stage_pl[0]    = issue_pl;
    assign stage_valid[0] = issue;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        mul_pipe_stage u_stage (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (stage_valid[g]),
            .in_pl      (stage_pl[g]),
            .prmiss     (prmiss),
            .prsuccess  (prsuccess),
            .prtag      (prtag),
            .specfixtag (specfixtag),
            .valid      (stage_valid[g+1]),
            .pl         (stage_pl[g+1])
        );
    end

`ifdef MUL_OUT_REG_EN
    mul_payload_t last_sel_pl;
    logic         unused_out;

    // Narrow to the selected word ahead of the output register so result leaves straight from a flop.
    always_comb begin
        last_sel_pl          = stage_pl[STAGES];
        last_sel_pl.sel_lohi = 1'b0;
        last_sel_pl.prod     = {{`DATA_LEN{1'b0}}, sel_word(stage_pl[STAGES])};
    end

    mul_pipe_stage u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (stage_valid[STAGES]),
        .in_pl      (last_sel_pl),
        .prmiss     (prmiss),
        .prsuccess  (prsuccess),
        .prtag      (prtag),
        .specfixtag (specfixtag),
        .valid      (out_valid),
        .pl         (out_pl)
    );

    assign result     = out_pl.prod[`DATA_LEN-1:0];
    assign unused_out = ^{out_pl.specbit, out_pl.sel_lohi, out_pl.prod[2*`DATA_LEN-1:`DATA_LEN]};
`else
    logic unused_out;

    assign out_valid  = stage_valid[STAGES];
    assign out_pl     = stage_pl[STAGES];
    assign result     = sel_word(out_pl);
    assign unused_out = out_pl.specbit;
`endif

    // An op leaving the pipe in a mispredict cycle that hits its tag is suppressed here.
    assign kill_spec   = out_valid & prmiss & (|(out_pl.spectag & specfixtag));
    assign rob_we      = out_valid & ~kill_spec;
    assign rrf_we      = rob_we & out_pl.dstval;
    assign wrrftag     = out_pl.rrftag;
    assign busy_stages = stage_valid[STAGES:1];

endmodule

// File: tb/tb_exunit_mul_pipe.sv
// tb/tb_exunit_mul_pipe.sv - scoreboard bench for exunit_mul_pipe
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef RRF_SEL
`define RRF_SEL 6
`endif
`ifndef SPECTAG_LEN
`define SPECTAG_LEN 5
`endif

module tb_exunit_mul_pipe;

    localparam int STAGES = 2;
`ifdef MUL_OUT_REG_EN
    localparam int LAT = STAGES + 1;
`else
    localparam int LAT = STAGES;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    issue;
    logic [`DATA_LEN-1:0]    ex_src1;
    logic [`DATA_LEN-1:0]    ex_src2;
    logic                    src1_signed;
    logic                    src2_signed;
    logic                    sel_lohi;
    logic [`RRF_SEL-1:0]     rrftag;
    logic                    dstval;
    logic [`SPECTAG_LEN-1:0] spectag;
    logic                    specbit;
    logic                    prmiss;
    logic                    prsuccess;
    logic [`SPECTAG_LEN-1:0] prtag;
    logic [`SPECTAG_LEN-1:0] specfixtag;
    logic [`DATA_LEN-1:0]    result;
    logic                    rrf_we;
    logic                    rob_we;
    logic [`RRF_SEL-1:0]     wrrftag;
    logic                    kill_spec;
    logic [STAGES-1:0]       busy_stages;

    exunit_mul_pipe #(.STAGES(STAGES)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue       (issue),
        .ex_src1     (ex_src1),
        .ex_src2     (ex_src2),
        .src1_signed (src1_signed),
        .src2_signed (src2_signed),
        .sel_lohi    (sel_lohi),
        .rrftag      (rrftag),
        .dstval      (dstval),
        .spectag     (spectag),
        .specbit     (specbit),
        .prmiss      (prmiss),
        .prsuccess   (prsuccess),
        .prtag       (prtag),
        .specfixtag  (specfixtag),
        .result      (result),
        .rrf_we      (rrf_we),
        .rob_we      (rob_we),
        .wrrftag     (wrrftag),
        .kill_spec   (kill_spec),
        .busy_stages (busy_stages)
    );

    always #5 clk = ~clk;

    // cyc counts rising edges; an op captured at edge N is expected while cyc == N+LAT-1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [`DATA_LEN-1:0] res;
        logic [`RRF_SEL-1:0]  tag;
        logic                 we;
        int                   due;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion is matched against the oldest expected result.
    always @(negedge clk) begin
        if (!reset && rob_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got tag %0d result 0x%0h expected none (cyc %0d)",
                         wrrftag, result, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("wrrftag", 64'(wrrftag), 64'(e.tag));
                chk("rrf_we", 64'(rrf_we), 64'(e.we));
                chk("latency_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Present one op for one edge; when push_exp is set its result is expected LAT cycles on.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s1, input logic s2,
                         input logic hi, input logic [`RRF_SEL-1:0] tag, input logic dv,
                         input logic [`SPECTAG_LEN-1:0] st, input logic sb,
                         input logic push_exp, input logic [31:0] exp_res);
        exp_t e;
        issue = 1'b1; ex_src1 = a; ex_src2 = b; src1_signed = s1; src2_signed = s2;
        sel_lohi = hi; rrftag = tag; dstval = dv; spectag = st; specbit = sb;
        if (push_exp) begin
            e.res = exp_res; e.tag = tag; e.we = dv; e.due = cyc + LAT;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        issue = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; issue = 1'b1; ex_src1 = 32'h5; ex_src2 = 32'h7;
        src1_signed = 1'b0; src2_signed = 1'b0; sel_lohi = 1'b0; rrftag = 6'd2;
        dstval = 1'b1; spectag = 5'b00001; specbit = 1'b0;
        prmiss = 1'b0; prsuccess = 1'b0; prtag = '0; specfixtag = '0;

        // Reset values, with an issue held during reset that must be ignored.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_result", 64'(result), 64'h0);
        chk("reset_rob_we", 64'(rob_we), 64'h0);
        chk("reset_rrf_we", 64'(rrf_we), 64'h0);
        chk("reset_kill_spec", 64'(kill_spec), 64'h0);
        chk("reset_wrrftag", 64'(wrrftag), 64'h0);
        chk("reset_busy", 64'(busy_stages), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0; issue = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", 64'(busy_stages), 64'h0);
        @(posedge clk);
        #1;

        // Product word selection across signedness modes.
        drive(32'hFFFFFFFF, 32'h00000002, 0, 0, 0, 6'd1, 1, 5'b00001, 0, 1, 32'hFFFFFFFE);
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 1, 6'd2, 1, 5'b00001, 0, 1, 32'h00000000);
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 6'd2, 1, 5'b00001, 0, 1, 32'hFFFFFFFE);
        drive(32'h80000000, 32'h00000002, 1, 0, 1, 6'd9, 1, 5'b00001, 0, 1, 32'hFFFFFFFF);
        drive(32'h00000007, 32'hFFFFFFFD, 1, 0, 1, 6'd11, 1, 5'b00001, 0, 1, 32'h00000006);
        drive(32'h00000007, 32'hFFFFFFFD, 1, 1, 0, 6'd12, 1, 5'b00001, 0, 1, 32'hFFFFFFEB);
        idle(LAT + 1);

        // Back-to-back issues on tags 3, 4, 5.
        drive(32'h00000003, 32'h00000005, 0, 0, 0, 6'd3, 1, 5'b00001, 0, 1, 32'h0000000F);
        drive(32'h00010000, 32'h00010000, 0, 0, 1, 6'd4, 1, 5'b00001, 0, 1, 32'h00000001);
        drive(32'h12345678, 32'h00000010, 0, 0, 0, 6'd5, 1, 5'b00001, 0, 1, 32'h23456780);
        idle(LAT + 1);

        // Mispredict: the 0b00010 op is in the output stage and the 0b01000 op one behind it.
        drive(32'h00000002, 32'h00000002, 0, 0, 0, 6'd6, 1, 5'b00010, 1, 0, 32'h0);
        drive(32'h00000003, 32'h00000004, 0, 0, 0, 6'd7, 0, 5'b01000, 1, 1, 32'h0000000C);
        idle(LAT - 2);
        prmiss = 1'b1; specfixtag = 5'b00110;
        issue = 1'b1; ex_src1 = 32'h9; ex_src2 = 32'h9; rrftag = 6'd10; dstval = 1'b1;
        spectag = 5'b00100; specbit = 1'b1;
        @(negedge clk);
        chk("miss_kill_spec", 64'(kill_spec), 64'h1);
        chk("miss_rob_we", 64'(rob_we), 64'h0);
        chk("miss_rrf_we", 64'(rrf_we), 64'h0);
        chk("miss_unresolved_specbit", 64'(dut.out_pl.specbit), 64'h1);
        @(posedge clk);
        #1;
        prmiss = 1'b0; specfixtag = '0; issue = 1'b0;
        idle(LAT + 2);

        // Resolve clears the speculative bit; a later mispredict on the same tag still squashes.
        drive(32'h00000005, 32'h00000005, 0, 0, 0, 6'd8, 1, 5'b00100, 1, 0, 32'h0);
        idle(LAT - 2);
        prsuccess = 1'b1; prtag = 5'b00100;
        @(posedge clk);
        #1;
        prsuccess = 1'b0; prtag = '0;
        prmiss = 1'b1; specfixtag = 5'b00100;
        @(negedge clk);
        chk("resolved_specbit", 64'(dut.out_pl.specbit), 64'h0);
        chk("resolved_kill_spec", 64'(kill_spec), 64'h1);
        chk("resolved_rob_we", 64'(rob_we), 64'h0);
        @(posedge clk);
        #1;
        prmiss = 1'b0; specfixtag = '0;
        idle(LAT + 2);

        // Reset mid-flight drops the op; the monitor flags any later completion.
        drive(32'h00000006, 32'h00000006, 0, 0, 0, 6'd13, 1, 5'b00001, 0, 0, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midflight_reset_busy", 64'(busy_stages), 64'h0);
        chk("midflight_reset_rob_we", 64'(rob_we), 64'h0);
        idle(LAT + 3);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
